mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Multi-cycle integer multiply/divide unit for the MIPS EX stage. It sits beside the combinational ALU and owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV and DIVU iteratively, one bit per cycle.
- Serves MFHI/MFLO reads and MTHI/MTLO writes.
- Raises busy/stall so the hazard unit can hold the pipeline.

Parameters:
- NB_DATA, 32, operand/HI/LO width (even, ≥4).
- NB_OP, 6, function-code width.
- NB_CNT, $clog2(NB_DATA), iteration counter width (derived; not overridden).

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  instruction valid for this unit this cycle.
- i_op  in  NB_OP  function code (MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011).
- i_datoA  in  NB_DATA  rs: multiplicand/dividend; MTHI/MTLO source.
- i_datoB  in  NB_DATA  rt: multiplier/divisor.
- i_abort  in  1  synchronous pipeline flush; kills an in-flight op.
- o_busy  out  1  state != IDLE.
- o_stall  out  1  o_busy & i_start.
- o_done  out  1  registered one-cycle pulse when HI/LO take a mul/div result.
- o_hi  out  NB_DATA  HI register.
- o_lo  out  NB_DATA  LO register.
- o_result  out  NB_DATA  combinational: HI if i_op==MFHI, LO if i_op==MFLO, else 0.

Behaviour:
- Reset (async, any state):
  - state=IDLE; HI=LO=0; o_done=0; o_busy=0; counter and datapath registers cleared.
  - Effect is immediate, not clock-gated.
- FSM IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - i_start with a mul/div op at edge E0:
    - latch magnitudes |A|, |B| (signed ops) or raw values (unsigned ops);
    - latch result-sign flags; cnt=0; -> CALC.
  - i_start with MTHI/MTLO at an edge: write HI (or LO) = i_datoA. Stay IDLE; no o_done.
  - MFHI/MFLO: pure combinational read, no state change.
  - Any other i_op: ignored.
- CALC:
  - One iteration per edge, for NB_DATA edges (E1..E_NB); at E_NB -> FIX.
  - Multiply: radix-2 shift-add into a 2*NB_DATA accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
- FIX (edge E_NB+1):
  - Apply sign correction and write HI/LO.
  - o_done=1 for exactly the following cycle; -> IDLE.
  - Latency: result visible NB_DATA+1 cycles after the accept edge; back-to-back op accepted in the o_done cycle.
- Sign rules:
  - Product negated if signs differ.
  - Quotient negated if signs differ; remainder takes the dividend's sign.
  - Multiply results: HI=product[2N-1:N], LO=product[N-1:0].
  - Divide results: LO=quotient, HI=remainder.
  - Most-negative magnitude (2^(N-1)) must be handled as unsigned N-bit.
- Overflow:
  - DIV 0x80000000 / -1 gives LO=0x80000000, HI=0 (wrap); no trap.
- Divide by zero (DIV/DIVU, B==0):
  - Same latency; LO=all ones, HI=i_datoA as latched; o_done pulses.
- i_start while busy:
  - Ignored, not queued; o_stall=1. The hazard unit must re-present the instruction.
  - MF*/MT* while busy are covered by the same stall.
- i_abort:
  - In CALC or FIX: -> IDLE at next edge; HI/LO unchanged; no o_done.
  - In IDLE: blocks acceptance that cycle.
  - i_abort beats a same-cycle i_start.
- Operands are sampled only at the accept edge; later input changes do not affect the result.

Decomposition:
- Package mips_alu_pkg:
  - function-code localparams (MULT..MTLO, shared with alu);
  - FSM state encoding;
  - helper function for mul/div op decode.
- One sub-module, mdu_iter_datapath: shared accumulator plus shift/add/subtract step, selected by a mul/div mode bit.
- FSM, sign handling and HI/LO live in mul_div_unit.

Test Plan:
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> o_busy 1 for 33 cycles; o_done pulse; HI=0xFFFFFFFE LO=0x00000001; MFHI/MFLO return same.
- MULT A=-8 B=3 -> HI=0xFFFFFFFF LO=0xFFFFFFE8; MULT 0x80000000*0x80000000 -> HI=0x40000000 LO=0.
- DIV A=-7 B=2 -> LO=0xFFFFFFFD HI=0xFFFFFFFF.
- DIVU A=7 B=2 -> LO=3 HI=1.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000 HI=0.
- DIVU A=0x12345678 B=0 -> LO=0xFFFFFFFF HI=0x12345678.
- MTHI 0xA5A5A5A5, MTLO 0x5A5A5A5A, then MULT 3*4 with i_abort at 10th CALC cycle -> o_busy 0 next cycle; HI=0xA5A5A5A5 LO=0x5A5A5A5A; no o_done.
- Start DIVU 100/7 during a busy MULT -> o_stall=1, ignored; re-issue after o_done -> LO=14 HI=2.
- i_rst pulse mid-CALC (no clock edge) -> HI=LO=0, o_busy=0 immediately.

Source files
------------

// File: rtl/mips_alu_pkg.sv
// Purpose : shared MIPS EX-stage definitions: function codes, mul/div FSM
//           state encoding and op-decode helpers.
// Ports   : none (package).
package mips_alu_pkg;

  localparam int unsigned NB_FUNCT = 6;

  // Function codes shared with the combinational ALU
  localparam logic [NB_FUNCT-1:0] OP_MFHI  = 6'b010000;
  localparam logic [NB_FUNCT-1:0] OP_MTHI  = 6'b010001;
  localparam logic [NB_FUNCT-1:0] OP_MFLO  = 6'b010010;
  localparam logic [NB_FUNCT-1:0] OP_MTLO  = 6'b010011;
  localparam logic [NB_FUNCT-1:0] OP_MULT  = 6'b011000;
  localparam logic [NB_FUNCT-1:0] OP_MULTU = 6'b011001;
  localparam logic [NB_FUNCT-1:0] OP_DIV   = 6'b011010;
  localparam logic [NB_FUNCT-1:0] OP_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

  // True for the four iterative ops
  function automatic logic op_is_muldiv(input logic [NB_FUNCT-1:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) ||
           (op == OP_DIV)  || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_div(input logic [NB_FUNCT-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [NB_FUNCT-1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Purpose : request/response bundle between the EX stage and mul_div_unit.
// Signals : i_start/i_op/i_datoA/i_datoB/i_abort (request, driven by master),
//           o_busy/o_stall/o_done/o_hi/o_lo/o_result (response, driven by slave).
interface mul_div_unit_if #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_OP   = 6
);
  logic               i_start;
  logic [NB_OP-1:0]   i_op;
  logic [NB_DATA-1:0] i_datoA;
  logic [NB_DATA-1:0] i_datoB;
  logic               i_abort;
  logic               o_busy;
  logic               o_stall;
  logic               o_done;
  logic [NB_DATA-1:0] o_hi;
  logic [NB_DATA-1:0] o_lo;
  logic [NB_DATA-1:0] o_result;

  modport master (
    output i_start, i_op, i_datoA, i_datoB, i_abort,
    input  o_busy, o_stall, o_done, o_hi, o_lo, o_result
  );

  modport slave (
    input  i_start, i_op, i_datoA, i_datoB, i_abort,
    output o_busy, o_stall, o_done, o_hi, o_lo, o_result
  );
endinterface

// File: rtl/mdu_iter_datapath.sv
// Purpose : one-bit-per-cycle iteration engine shared by multiply and divide.
//           Accumulator layout: multiply {partial product, multiplier};
//           divide {partial remainder, dividend/quotient}.
// Ports   : i_clk, i_rst (async, high); i_load latches i_acc_lo/i_opnd/i_div;
//           i_step performs one iteration; o_acc is the accumulator.
module mdu_iter_datapath #(
  parameter int unsigned NB_DATA = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_load,
  input  logic                   i_step,
  input  logic                   i_div,
  input  logic [NB_DATA-1:0]     i_acc_lo,
  input  logic [NB_DATA-1:0]     i_opnd,
  output logic [2*NB_DATA-1:0]   o_acc
);

  logic [2*NB_DATA-1:0] acc_q, acc_d;
  logic [NB_DATA-1:0]   opnd_q;
  logic                 div_q;

  logic [NB_DATA:0]     add_sum;
  logic [NB_DATA:0]     rem_sh;
  logic [NB_DATA-1:0]   rem_diff;
  logic                 rem_ge;

  // Single iteration step for both modes
  always_comb begin
    add_sum  = {1'b0, acc_q[2*NB_DATA-1:NB_DATA]}
             + (acc_q[0] ? {1'b0, opnd_q} : (NB_DATA+1)'(0));
    // Remainder shifted left with the next dividend bit; needs one extra bit
    rem_sh   = acc_q[2*NB_DATA-1:NB_DATA-1];
    rem_ge   = (rem_sh >= {1'b0, opnd_q});
    // Only used when rem_ge, where the true difference fits in NB_DATA bits
    rem_diff = rem_sh[NB_DATA-1:0] - opnd_q;
    if (div_q) begin
      acc_d = {(rem_ge ? rem_diff : rem_sh[NB_DATA-1:0]),
               acc_q[NB_DATA-2:0], rem_ge};
    end else begin
      acc_d = {add_sum, acc_q[NB_DATA-1:1]};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
    end else if (i_load) begin
      acc_q  <= {NB_DATA'(0), i_acc_lo};
      opnd_q <= i_opnd;
      div_q  <= i_div;
    end else if (i_step) begin
      acc_q  <= acc_d;
    end
  end

  assign o_acc = acc_q;

endmodule

// File: rtl/mul_div_unit.sv
// Purpose : iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, plus MFHI/MFLO
//           reads and MTHI/MTLO writes.
// Ports   : i_clk, i_rst (async, high); bus (slave): i_start, i_op, i_datoA,
//           i_datoB, i_abort in; o_busy, o_stall (comb), o_done, o_hi, o_lo,
//           o_result (comb HI/LO read mux) out.
module mul_div_unit
  import mips_alu_pkg::*;
#(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_OP   = 6
) (
  input  logic           i_clk,
  input  logic           i_rst,
  mul_div_unit_if.slave  bus
);

  localparam int unsigned NB_CNT = $clog2(NB_DATA);

  mdu_state_e           state_q;
  logic [NB_CNT-1:0]    cnt_q;
  logic                 is_div_q;
  logic                 neg_res_q;
  logic                 neg_rem_q;
  logic                 dbz_q;
  logic [NB_DATA-1:0]   a_raw_q;
  logic [NB_DATA-1:0]   hi_q, lo_q;
  logic                 done_q;

  logic [NB_OP-1:0]     op_c;
  logic [NB_DATA-1:0]   a_c, b_c, a_mag_c, b_mag_c;
  logic                 sgn_c, a_neg_c, b_neg_c, div_op_c;
  logic                 accept_c, mt_c, step_c;
  logic [2*NB_DATA-1:0] acc;
  logic [2*NB_DATA-1:0] prod_c;
  logic [NB_DATA-1:0]   quo_c, rem_c, hi_fix_c, lo_fix_c;

  // Operand decode and magnitude extraction at the accept edge
  always_comb begin
    op_c     = bus.i_op;
    a_c      = bus.i_datoA;
    b_c      = bus.i_datoB;
    sgn_c    = op_is_signed(op_c);
    div_op_c = op_is_div(op_c);
    a_neg_c  = sgn_c & a_c[NB_DATA-1];
    b_neg_c  = sgn_c & b_c[NB_DATA-1];
    // 2^(N-1) negates to itself, which is the correct unsigned magnitude
    a_mag_c  = a_neg_c ? (~a_c + NB_DATA'(1)) : a_c;
    b_mag_c  = b_neg_c ? (~b_c + NB_DATA'(1)) : b_c;
    accept_c = (state_q == ST_IDLE) && bus.i_start && !bus.i_abort &&
               op_is_muldiv(op_c);
    mt_c     = (state_q == ST_IDLE) && bus.i_start && !bus.i_abort &&
               ((op_c == OP_MTHI) || (op_c == OP_MTLO));
    step_c   = (state_q == ST_CALC) && !bus.i_abort;
  end

  mdu_iter_datapath #(.NB_DATA(NB_DATA)) u_iter (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (accept_c),
    .i_step   (step_c),
    .i_div    (div_op_c),
    .i_acc_lo (div_op_c ? a_mag_c : b_mag_c),
    .i_opnd   (div_op_c ? b_mag_c : a_mag_c),
    .o_acc    (acc)
  );

  // Sign correction of the raw magnitude result
  always_comb begin
    prod_c = neg_res_q ? (~acc + (2*NB_DATA)'(1)) : acc;
    quo_c  = neg_res_q ? (~acc[NB_DATA-1:0] + NB_DATA'(1)) : acc[NB_DATA-1:0];
    rem_c  = neg_rem_q ? (~acc[2*NB_DATA-1:NB_DATA] + NB_DATA'(1))
                       : acc[2*NB_DATA-1:NB_DATA];
    if (dbz_q) begin
      hi_fix_c = a_raw_q;
      lo_fix_c = '1;
    end else if (is_div_q) begin
      hi_fix_c = rem_c;
      lo_fix_c = quo_c;
    end else begin
      hi_fix_c = prod_c[2*NB_DATA-1:NB_DATA];
      lo_fix_c = prod_c[NB_DATA-1:0];
    end
  end

  // Control FSM, HI/LO and done pulse
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      a_raw_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            is_div_q  <= div_op_c;
            neg_res_q <= a_neg_c ^ b_neg_c;
            neg_rem_q <= a_neg_c;
            dbz_q     <= div_op_c && (b_c == '0);
            a_raw_q   <= a_c;
            cnt_q     <= '0;
            state_q   <= ST_CALC;
          end else if (mt_c) begin
            if (op_c == OP_MTHI) hi_q <= a_c;
            else                 lo_q <= a_c;
          end
        end
        ST_CALC: begin
          if (bus.i_abort) begin
            state_q <= ST_IDLE;
          end else if (cnt_q == NB_CNT'(NB_DATA-1)) begin
            state_q <= ST_FIX;
          end else begin
            cnt_q <= cnt_q + NB_CNT'(1);
          end
        end
        ST_FIX: begin
          if (!bus.i_abort) begin
            hi_q   <= hi_fix_c;
            lo_q   <= lo_fix_c;
            done_q <= 1'b1;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_busy   = (state_q != ST_IDLE);
  assign bus.o_stall  = (state_q != ST_IDLE) & bus.i_start;
  assign bus.o_done   = done_q;
  assign bus.o_hi     = hi_q;
  assign bus.o_lo     = lo_q;
  assign bus.o_result = (op_c == OP_MFHI) ? hi_q :
                        (op_c == OP_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_mul_div_unit.sv
// Purpose : directed self-checking bench for mul_div_unit.
module tb_mul_div_unit;
  import mips_alu_pkg::*;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  mul_div_unit_if #(.NB_DATA(32), .NB_OP(6)) bus ();

  mul_div_unit #(.NB_DATA(32), .NB_OP(6)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for exactly one edge, then scramble operands
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.i_start = 1'b1;
    bus.i_op    = op;
    bus.i_datoA = a;
    bus.i_datoB = b;
    tick();
    bus.i_start = 1'b0;
    bus.i_op    = 6'b000000;
    bus.i_datoA = 32'hDEAD_BEEF;
    bus.i_datoB = 32'h0BAD_F00D;
  endtask

  // Wait (bounded) for busy to drop; reports the number of busy cycles
  task automatic wait_idle(output int cycles);
    cycles = 1;
    while (bus.o_busy === 1'b1 && cycles < 100) begin
      tick();
      if (bus.o_busy === 1'b1) cycles++;
    end
  endtask

  // Run an op to completion and check latency, done pulse and HI/LO
  task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int cyc;
    issue(op, a, b);
    wait_idle(cyc);
    check({tag, "_latency"}, 32'(cyc), 32'd33);
    check({tag, "_done"},    32'(bus.o_done), 32'd1);
    check({tag, "_hi"},      bus.o_hi, exp_hi);
    check({tag, "_lo"},      bus.o_lo, exp_lo);
  endtask

  initial begin
    int  cyc;
    logic done_seen;
    rst         = 1'b1;
    bus.i_start = 1'b0;
    bus.i_op    = 6'b000000;
    bus.i_datoA = '0;
    bus.i_datoB = '0;
    bus.i_abort = 1'b0;
    #12;
    rst = 1'b0;
    tick();

    check("reset_hi",   bus.o_hi, 32'h0);
    check("reset_lo",   bus.o_lo, 32'h0);
    check("reset_busy", 32'(bus.o_busy), 32'd0);
    check("reset_done", 32'(bus.o_done), 32'd0);

    // MULTU max*max, with MFHI/MFLO readback and one-cycle done
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    bus.i_op = OP_MFHI; #1;
    check("mfhi", bus.o_result, 32'hFFFF_FFFE);
    bus.i_op = OP_MFLO; #1;
    check("mflo", bus.o_result, 32'h0000_0001);
    bus.i_op = 6'b100000; #1;
    check("result_other_op", bus.o_result, 32'h0);
    tick();
    check("done_one_cycle", 32'(bus.o_done), 32'd0);

    run_op("mult_neg",   OP_MULT, 32'hFFFF_FFF8, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFE8);
    run_op("mult_minsq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    run_op("div_neg",    OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_7_2",   OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
    run_op("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_op("divu_zero",  OP_DIVU, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF);

    // MTHI / MTLO
    issue(OP_MTHI, 32'hA5A5_A5A5, 32'h0);
    check("mthi_hi",   bus.o_hi, 32'hA5A5_A5A5);
    check("mthi_busy", 32'(bus.o_busy), 32'd0);
    issue(OP_MTLO, 32'h5A5A_5A5A, 32'h0);
    check("mtlo_lo",   bus.o_lo, 32'h5A5A_5A5A);
    check("mtlo_done", 32'(bus.o_done), 32'd0);

    // Abort in the 10th CALC cycle
    issue(OP_MULT, 32'd3, 32'd4);
    for (int i = 0; i < 9; i++) tick();
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    check("abort_busy", 32'(bus.o_busy), 32'd0);
    done_seen = bus.o_done;
    for (int i = 0; i < 30; i++) begin
      tick();
      done_seen = done_seen | bus.o_done;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    check("abort_hi", bus.o_hi, 32'hA5A5_A5A5);
    check("abort_lo", bus.o_lo, 32'h5A5A_5A5A);

    // Abort beats a same-cycle start in IDLE
    bus.i_abort = 1'b1;
    issue(OP_MTHI, 32'h1111_1111, 32'h0);
    bus.i_abort = 1'b0;
    check("abort_idle_hi", bus.o_hi, 32'hA5A5_A5A5);

    // Start while busy is stalled and ignored; re-issue back-to-back
    issue(OP_MULT, 32'd5, 32'd6);
    bus.i_start = 1'b1;
    bus.i_op    = OP_DIVU;
    bus.i_datoA = 32'd100;
    bus.i_datoB = 32'd7;
    #1;
    check("stall", 32'(bus.o_stall), 32'd1);
    tick();
    bus.i_start = 1'b0;
    bus.i_op    = 6'b000000;
    wait_idle(cyc);
    check("stall_mult_latency", 32'(cyc), 32'd32);
    check("stall_mult_lo", bus.o_lo, 32'd30);
    check("stall_mult_hi", bus.o_hi, 32'd0);
    run_op("divu_reissue", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

    // Asynchronous reset between clock edges
    issue(OP_MULT, 32'd3, 32'd4);
    for (int i = 0; i < 5; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_hi",   bus.o_hi, 32'h0);
    check("arst_lo",   bus.o_lo, 32'h0);
    check("arst_busy", 32'(bus.o_busy), 32'd0);
    rst = 1'b0;
    tick();
    tick();
    check("arst_stays_idle", 32'(bus.o_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
